// File: rtl/sim_data_mem_if.sv
// rtl/sim_data_mem_if.sv - request/response bus between a data-port requester and sim_data_mem
interface sim_data_mem_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int NB = DATA_WIDTH / 8;

   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_addr;
   logic                  req_wen;
   logic [NB-1:0]         req_wmask;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_addr, req_wen, req_wmask, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_wen, req_wmask, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/sim_data_mem.sv
// rtl/sim_data_mem.sv - self-timed byte-addressed data memory model with wait states,
// byte-lane writes, range errors and saturating access counters.
module sim_data_mem #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_BYTES = 4096,
   parameter int LATENCY     = 1,
   parameter     INIT_FILE   = ""
) (
   input  logic          clk,
   input  logic          rst,
   sim_data_mem_if.slave bus,
   output logic [31:0]   rd_count,
   output logic [31:0]   wr_count
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int LB = $clog2(NB);
   localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   logic [7:0] mem [0:DEPTH_BYTES-1];

   state_t                state;
   logic [3:0]            wait_cnt;
   logic [31:0]           addr_q;
   logic                  wen_q;
   logic [NB-1:0]         wmask_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   // With zero latency the commit happens on the accept edge, so it must use the live inputs.
   logic                  from_idle;
   logic                  enter_resp;
   logic [31:0]           c_addr;
   logic                  c_wen;
   logic [NB-1:0]         c_wmask;
   logic [DATA_WIDTH-1:0] c_wdata;
   logic                  c_err;
   logic [AW-1:0]         c_base;
   logic [DATA_WIDTH-1:0] c_word;

   always_comb begin
      from_idle  = (state == IDLE);
      enter_resp = from_idle ? (bus.req_valid && (LATENCY == 0))
                             : ((state == BUSY) && (wait_cnt == 4'd0));
      c_addr     = from_idle ? bus.req_addr  : addr_q;
      c_wen      = from_idle ? bus.req_wen   : wen_q;
      c_wmask    = from_idle ? bus.req_wmask : wmask_q;
      c_wdata    = from_idle ? bus.req_wdata : wdata_q;
      c_err      = (c_addr >= 32'(DEPTH_BYTES));
      c_base     = {c_addr[AW-1:LB], {LB{1'b0}}};
      c_word     = '0;
      for (int i = 0; i < NB; i++) begin
         c_word[8*i +: 8] = (c_wen && c_wmask[i]) ? c_wdata[8*i +: 8]
                                                  : mem[c_base | AW'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wait_cnt      <= 4'd0;
         bus.req_ready <= 1'b1;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err  <= 1'b0;
         rd_count      <= 32'd0;
         wr_count      <= 32'd0;
         addr_q        <= 32'd0;
         wen_q         <= 1'b0;
         wmask_q       <= '0;
         wdata_q       <= '0;
      end else begin
         if (enter_resp) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= c_err;
            bus.resp_rdata <= c_err ? '0 : c_word;
            if (!c_err) begin
               if (c_wen) begin
                  for (int i = 0; i < NB; i++) begin
                     mem[c_base | AW'(i)] <= c_word[8*i +: 8];
                  end
                  if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
               end else if (rd_count != 32'hFFFF_FFFF) begin
                  rd_count <= rd_count + 32'd1;
               end
            end
         end
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q        <= bus.req_addr;
                  wen_q         <= bus.req_wen;
                  wmask_q       <= bus.req_wmask;
                  wdata_q       <= bus.req_wdata;
                  bus.req_ready <= 1'b0;
                  if (LATENCY != 0) begin
                     state    <= BUSY;
                     wait_cnt <= LAT_M1;
                  end
               end
            end
            BUSY: begin
               if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            end
            RESP: begin
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
